hazard_controller: RTL and testbench
====================================

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 15: maximum consecutive data-memory wait cycles before a timeout.
REQ-002 SHALL have parameter CNT_W, default 16: width of the performance counters.
REQ-003 SHALL have one clock; reset is synchronous and active-high; ports are named clk and rst.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 R2_1, R3_1  in  4 each  source register addresses of the decode-stage instruction.
REQ-007 ExtndSel1  in  2  operand-use code of the decode-stage instruction: bit1=1 means R2 and R3 are unused; bit0=1 means R3 is unused.
REQ-008 DestR_2  in  4  destination register of the execute-stage instruction.
REQ-009 MemRd_2  in  1  execute-stage instruction is a load.
REQ-010 BranchTaken_3  in  1  branch resolved taken in stage 3.
REQ-011 MemReq_4, MemReady_4  in  1 each  data-memory request / ready handshake in stage 4.
REQ-012 CntClr  in  1  clears both performance counters.
REQ-013 StallF, StallD, StallE, StallM  out  1 each  hold the pipeline register feeding each stage.
REQ-014 FlushD, FlushE, FlushW  out  1 each  insert a bubble into the named stage.
REQ-015 MemTimeout  out  1  sticky memory-timeout error.
REQ-016 State  out  2  current FSM state encoding.
REQ-017 StallCnt, FlushCnt  out  CNT_W each  saturating performance counters.

Function
REQ-018 FSM states SHALL be RUN=0, MEM_WAIT=1 and ERR=2; encoding 3 is illegal and SHALL return to RUN.
REQ-019 memStall SHALL be MemReq_4 & ~MemReady_4 while in RUN or MEM_WAIT.
REQ-020 RUN: if memStall, the FSM SHALL go to MEM_WAIT and load wait count wcnt=1; otherwise it SHALL stay in RUN.
REQ-021 MEM_WAIT, MemReady_4=1: the FSM SHALL go to RUN, with no stall in that cycle.
REQ-022 MEM_WAIT, MemReady_4=0 and wcnt==WAIT_MAX: the FSM SHALL go to ERR.
REQ-023 MEM_WAIT, otherwise: wcnt SHALL increment.
REQ-024 MEM_WAIT, MemReq_4 deasserts: the FSM SHALL return to RUN (aborted request).
REQ-025 ERR SHALL be exited only by rst; MemTimeout=1 in ERR.
REQ-026 Outputs SHALL be combinational from state and inputs, with priority ERR > memStall > branch > load-use.
REQ-027 ERR or memStall: StallF=StallD=StallE=StallM=1, FlushW=1, and all other flushes 0.
REQ-028 Branch (BranchTaken_3, no memStall): FlushD=FlushE=1, no stalls, and load-use ignored.
REQ-029 Load-use (MemRd_2 and DestR_2 equals a used source per ExtndSel1): StallF=StallD=1, FlushE=1.
REQ-030 In the load-use check, R2_1 SHALL be used iff ExtndSel1[1]=0, and R3_1 iff ExtndSel1==2'b00.
REQ-031 Register address 0 SHALL have no special case.
REQ-032 With no hazard, all stall and flush outputs SHALL be 0.
REQ-033 StallCnt SHALL increment on each cycle with StallF=1.
REQ-034 FlushCnt SHALL increment on each cycle with a branch flush.
REQ-035 Both counters SHALL saturate at all-ones.
REQ-036 CntClr SHALL zero both counters and has priority over increment.

Reset
REQ-037 rst SHALL force State=RUN, wcnt=0, MemTimeout=0, StallCnt=0 and FlushCnt=0 on the next edge.
REQ-038 rst SHALL override every state, including ERR and MEM_WAIT mid-wait.
REQ-039 During the rst cycle, outputs SHALL reflect the pre-edge state.

Structure
REQ-040 The state enum SHALL be defined in the shared package cpu_pkg.
REQ-041 The register-address width (4) and data width (32) SHALL be defined in cpu_pkg as constants.
REQ-042 One sub-module, sat_counter, SHALL be parameterised by CNT_W and instantiated twice.

Verification
REQ-043 Load-use: MemRd_2=1, DestR_2=5, R3_1=5, ExtndSel1=00 -> StallF=StallD=FlushE=1 for one cycle; with ExtndSel1=01 -> no stall.
REQ-044 Branch with load-use: BranchTaken_3=1 and load-use true -> FlushD=FlushE=1, StallF=0, FlushCnt increments by 1.
REQ-045 Memory wait: MemReq_4=1, MemReady_4=0 for 3 cycles, then 1 -> four stalls active for 3 cycles, State 0->1->1->1->0, StallCnt=3.
REQ-046 Timeout: MemReady_4 held 0 with WAIT_MAX=15 -> ERR after 16 stall cycles, MemTimeout=1 and held; rst -> State=0, MemTimeout=0.
REQ-047 Counters: force 65535 stall cycles plus 1 more -> StallCnt=16'hFFFF; CntClr together with a stall -> 0.
REQ-048 Memory stall plus branch: memStall and BranchTaken_3 in the same cycle -> stalls only; FlushD asserted in the first cycle after MemReady_4.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register/data widths,
// hazard FSM states and the operand-use match helper.
package cpu_pkg;

  localparam int REG_W  = 4;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } hz_state_e;

  // sel[1]: R2 and R3 unused; sel[0]: R3 unused
  function automatic logic src_hit(
    input logic [REG_W-1:0] dst,
    input logic [REG_W-1:0] r2,
    input logic [REG_W-1:0] r3,
    input logic [1:0]       sel
  );
    return (!sel[1] && dst == r2) ||
           (sel == 2'b00 && dst == r3);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with clear;
// clear wins over increment.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && count != '1) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard control: load-use, branch flush,
// data-memory wait with timeout, stall/flush counters.
module hazard_controller
  import cpu_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] R2_1,
  input  logic [REG_W-1:0] R3_1,
  input  logic [1:0]       ExtndSel1,
  input  logic [REG_W-1:0] DestR_2,
  input  logic             MemRd_2,
  input  logic             BranchTaken_3,
  input  logic             MemReq_4,
  input  logic             MemReady_4,
  input  logic             CntClr,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MemTimeout,
  output logic [1:0]       State,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  localparam int WC_W = $clog2(WAIT_MAX + 1);

  hz_state_e       state, state_nx;
  logic [WC_W-1:0] wcnt, wcnt_nx;
  logic            mem_stall, lu_hit;
  logic            hold, br_hz, lu_hz;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      wcnt  <= '0;
    end else begin
      state <= state_nx;
      wcnt  <= wcnt_nx;
    end
  end

  assign mem_stall = (state == RUN || state == MEM_WAIT)
                   && MemReq_4 && !MemReady_4;

  always_comb begin
    state_nx = RUN;
    wcnt_nx  = wcnt;
    unique case (state)
      RUN: begin
        if (mem_stall) begin
          state_nx = MEM_WAIT;
          wcnt_nx  = WC_W'(1);
        end
      end
      MEM_WAIT: begin
        if (!MemReq_4 || MemReady_4) begin
          state_nx = RUN;
          wcnt_nx  = '0;
        end else if (wcnt == WC_W'(WAIT_MAX)) begin
          state_nx = ERR;
        end else begin
          state_nx = MEM_WAIT;
          wcnt_nx  = wcnt + WC_W'(1);
        end
      end
      ERR: state_nx = ERR;
      default: begin
        state_nx = RUN;
        wcnt_nx  = '0;
      end
    endcase
  end

  assign lu_hit = MemRd_2 &&
    src_hit(DestR_2, R2_1, R3_1, ExtndSel1);

  // one-hot hazard classes in priority order
  assign hold  = (state == ERR) || mem_stall;
  assign br_hz = BranchTaken_3 && !hold;
  assign lu_hz = lu_hit && !BranchTaken_3 && !hold;

  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    unique case (1'b1)
      hold: begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end
      br_hz: begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end
      lu_hz: begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
      default: ;
    endcase
  end

  assign MemTimeout = (state == ERR);
  assign State      = state;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (CntClr),
    .inc   (StallF),
    .count (StallCnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (CntClr),
    .inc   (br_hz),
    .count (FlushCnt)
  );

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller:
// directed scenarios plus randomized run vs. a model.
module tb_hazard_controller;
  import cpu_pkg::*;

  localparam int WAIT_MAX = 15;
  localparam int CNT_W    = 16;
  localparam int CMAX     = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [REG_W-1:0] R2_1, R3_1, DestR_2;
  logic [1:0]       ExtndSel1;
  logic             MemRd_2, BranchTaken_3;
  logic             MemReq_4, MemReady_4, CntClr;
  logic             StallF, StallD, StallE, StallM;
  logic             FlushD, FlushE, FlushW;
  logic             MemTimeout;
  logic [1:0]       State;
  logic [CNT_W-1:0] StallCnt, FlushCnt;

  int checks = 0;
  int errors = 0;

  // model: consecutive pending cycles, timed-out flag,
  // event counts
  int m_wait = 0;
  bit m_to   = 1'b0;
  int m_scnt = 0;
  int m_fcnt = 0;

  hazard_controller #(
    .WAIT_MAX(WAIT_MAX),
    .CNT_W   (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .R2_1         (R2_1),
    .R3_1         (R3_1),
    .ExtndSel1    (ExtndSel1),
    .DestR_2      (DestR_2),
    .MemRd_2      (MemRd_2),
    .BranchTaken_3(BranchTaken_3),
    .MemReq_4     (MemReq_4),
    .MemReady_4   (MemReady_4),
    .CntClr       (CntClr),
    .StallF       (StallF),
    .StallD       (StallD),
    .StallE       (StallE),
    .StallM       (StallM),
    .FlushD       (FlushD),
    .FlushE       (FlushE),
    .FlushW       (FlushW),
    .MemTimeout   (MemTimeout),
    .State        (State),
    .StallCnt     (StallCnt),
    .FlushCnt     (FlushCnt)
  );

  always #5 clk = ~clk;

  wire [6:0] obs = {StallF, StallD, StallE, StallM,
                    FlushD, FlushE, FlushW};

  localparam logic [6:0] C_NONE = 7'b0000_000;
  localparam logic [6:0] C_HOLD = 7'b1111_001;
  localparam logic [6:0] C_BR   = 7'b0000_110;
  localparam logic [6:0] C_LU   = 7'b1100_010;

  function automatic bit pending();
    return MemReq_4 && !MemReady_4 && !m_to;
  endfunction

  function automatic logic [6:0] exp_ctl();
    bit lu;
    lu = MemRd_2 &&
      ((!ExtndSel1[1] && DestR_2 == R2_1) ||
       (ExtndSel1 == 2'b00 && DestR_2 == R3_1));
    if (m_to || pending()) return C_HOLD;
    if (BranchTaken_3) return C_BR;
    if (lu) return C_LU;
    return C_NONE;
  endfunction

  function automatic logic [1:0] exp_state();
    if (m_to) return 2'd2;
    return (m_wait > 0) ? 2'd1 : 2'd0;
  endfunction

  always @(posedge clk) begin
    logic [6:0] e;
    int w, s, f;
    bit t;
    e = exp_ctl();
    w = m_wait;
    t = m_to;
    s = m_scnt;
    f = m_fcnt;
    if (rst) begin
      w = 0; t = 1'b0; s = 0; f = 0;
    end else begin
      if (CntClr) begin
        s = 0; f = 0;
      end else begin
        if (e[6] && s < CMAX) s++;
        if (e[2] && f < CMAX) f++;
      end
      if (!t) begin
        if (pending()) begin
          w++;
          if (w > WAIT_MAX) t = 1'b1;
        end else begin
          w = 0;
        end
      end
    end
    m_wait <= w;
    m_to   <= t;
    m_scnt <= s;
    m_fcnt <= f;
  end

  task automatic idle();
    R2_1 = '0; R3_1 = '0; DestR_2 = '0;
    ExtndSel1 = 2'b00; MemRd_2 = 1'b0;
    BranchTaken_3 = 1'b0; MemReq_4 = 1'b0;
    MemReady_4 = 1'b0; CntClr = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (State !== 2'd0 || MemTimeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got %0d/%b want 0/0",
               State, MemTimeout);
    end
    checks++;
    if (StallCnt !== '0 || FlushCnt !== '0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d/%0d want 0/0",
               StallCnt, FlushCnt);
    end
    checks++;
    if (obs !== C_NONE) begin
      errors++;
      $display("FAIL reset_ctl: got %b want %b",
               obs, C_NONE);
    end
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [3:0] dst, r2, r3;
    logic [1:0] sel;
    logic [6:0] exp;
  } lu_vec_t;

  task automatic test_load_use();
    lu_vec_t v[6];
    v[0] = '{4'd5, 4'd7, 4'd5, 2'b00, C_LU};
    v[1] = '{4'd5, 4'd7, 4'd5, 2'b01, C_NONE};
    v[2] = '{4'd5, 4'd5, 4'd9, 2'b01, C_LU};
    v[3] = '{4'd5, 4'd5, 4'd5, 2'b10, C_NONE};
    v[4] = '{4'd0, 4'd0, 4'd3, 2'b01, C_LU};
    v[5] = '{4'd6, 4'd7, 4'd8, 2'b00, C_NONE};
    do_reset();
    foreach (v[i]) begin
      MemRd_2 = 1'b1;
      DestR_2 = v[i].dst;
      R2_1 = v[i].r2;
      R3_1 = v[i].r3;
      ExtndSel1 = v[i].sel;
      @(negedge clk);
      checks++;
      if (obs !== v[i].exp) begin
        errors++;
        $display("FAIL load_use[%0d]: got %b want %b",
                 i, obs, v[i].exp);
      end
      tick();
    end
    MemRd_2 = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== C_NONE) begin
      errors++;
      $display("FAIL load_use_norD: got %b want %b",
               obs, C_NONE);
    end
    tick();
  endtask

  task automatic test_branch();
    do_reset();
    MemRd_2 = 1'b1;
    DestR_2 = 4'd5;
    R3_1 = 4'd5;
    BranchTaken_3 = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== C_BR) begin
      errors++;
      $display("FAIL branch_lu: got %b want %b",
               obs, C_BR);
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (FlushCnt !== 16'd1 || StallCnt !== 16'd0) begin
      errors++;
      $display("FAIL branch_cnt: got %0d/%0d want 1/0",
               FlushCnt, StallCnt);
    end
    tick();
  endtask

  task automatic test_mem_wait();
    do_reset();
    MemReq_4 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== C_HOLD ||
          State !== ((i == 0) ? 2'd0 : 2'd1)) begin
        errors++;
        $display("FAIL mem_wait[%0d]: got %b st %0d",
                 i, obs, State);
      end
      tick();
    end
    MemReady_4 = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== C_NONE || State !== 2'd1) begin
      errors++;
      $display("FAIL mem_ready: got %b st %0d want %b st 1",
               obs, State, C_NONE);
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (State !== 2'd0 || StallCnt !== 16'd3) begin
      errors++;
      $display("FAIL mem_done: got st %0d cnt %0d want 0/3",
               State, StallCnt);
    end
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    MemReq_4 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== C_HOLD || MemTimeout !== 1'b0 ||
          State !== ((i == 0) ? 2'd0 : 2'd1)) begin
        errors++;
        $display("FAIL timeout_wait[%0d]: got %b st %0d",
                 i, obs, State);
      end
      tick();
    end
    MemReq_4 = 1'b0;
    MemReady_4 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (State !== 2'd2 || MemTimeout !== 1'b1 ||
          obs !== C_HOLD) begin
        errors++;
        $display("FAIL timeout_err[%0d]: got st %0d to %b",
                 i, State, MemTimeout);
      end
      tick();
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (State !== 2'd2 || MemTimeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_rst_pre: got st %0d want 2",
               State);
    end
    tick();
    rst = 1'b0;
    idle();
    @(negedge clk);
    checks++;
    if (State !== 2'd0 || MemTimeout !== 1'b0 ||
        obs !== C_NONE) begin
      errors++;
      $display("FAIL timeout_rst: got st %0d to %b",
               State, MemTimeout);
    end
    tick();
  endtask

  task automatic test_mem_branch();
    do_reset();
    MemReq_4 = 1'b1;
    BranchTaken_3 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== C_HOLD || FlushCnt !== 16'd0) begin
        errors++;
        $display("FAIL mem_br[%0d]: got %b fc %0d",
                 i, obs, FlushCnt);
      end
      tick();
    end
    MemReady_4 = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== C_BR) begin
      errors++;
      $display("FAIL mem_br_rel: got %b want %b",
               obs, C_BR);
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (FlushCnt !== 16'd1 || StallCnt !== 16'd2) begin
      errors++;
      $display("FAIL mem_br_cnt: got %0d/%0d want 1/2",
               FlushCnt, StallCnt);
    end
    tick();
  endtask

  task automatic test_random();
    int hits = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      MemReq_4 = ($urandom_range(0, 2) == 0);
      if (i < 1500)
        MemReady_4 = $urandom_range(0, 1) == 1;
      else
        MemReady_4 = $urandom_range(0, 19) == 0;
      BranchTaken_3 = ($urandom_range(0, 5) == 0);
      MemRd_2 = $urandom_range(0, 1) == 1;
      DestR_2 = 4'($urandom_range(0, 3));
      R2_1 = 4'($urandom_range(0, 3));
      R3_1 = 4'($urandom_range(0, 3));
      ExtndSel1 = 2'($urandom_range(0, 3));
      CntClr = ($urandom_range(0, 49) == 0);
      @(negedge clk);
      if (m_to) hits++;
      checks++;
      if (obs !== exp_ctl() || State !== exp_state() ||
          MemTimeout !== m_to ||
          StallCnt !== CNT_W'(m_scnt) ||
          FlushCnt !== CNT_W'(m_fcnt)) begin
        errors++;
        $display("FAIL rand[%0d]: got %b st %0d sc %0d fc %0d want %b st %0d sc %0d fc %0d",
                 i, obs, State, StallCnt, FlushCnt,
                 exp_ctl(), exp_state(), m_scnt, m_fcnt);
      end
      tick();
    end
    rst = 1'b0;
    $display("random: %0d cycles in timeout", hits);
  endtask

  task automatic test_counters();
    do_reset();
    MemReq_4 = 1'b1;
    repeat (CMAX - 1) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (StallCnt !== 16'hFFFE) begin
      errors++;
      $display("FAIL cnt_pre: got %h want fffe", StallCnt);
    end
    tick();
    @(negedge clk);
    checks++;
    if (StallCnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL cnt_max: got %h want ffff", StallCnt);
    end
    tick();
    @(negedge clk);
    checks++;
    if (StallCnt !== 16'hFFFF || obs !== C_HOLD) begin
      errors++;
      $display("FAIL cnt_sat: got %h want ffff", StallCnt);
    end
    CntClr = 1'b1;
    tick();
    CntClr = 1'b0;
    @(negedge clk);
    checks++;
    if (StallCnt !== 16'h0000) begin
      errors++;
      $display("FAIL cnt_clr: got %h want 0", StallCnt);
    end
    tick();
    @(negedge clk);
    checks++;
    if (StallCnt !== 16'h0001) begin
      errors++;
      $display("FAIL cnt_restart: got %h want 1", StallCnt);
    end
    tick();
    do_reset();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_mem_branch();
    test_random();
    test_counters();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
